// File: rtl/ifetch_512.sv
// ifetch_512: instruction-fetch stage for a 512x32 word memory.
// Holds the PC and issues one read per cycle into a memory with a fixed
// one-cycle read latency. Returned words go to decode over a valid/ready
// handshake. A two-entry skid buffer absorbs back-pressure, and each
// request carries an epoch tag so that words fetched before a redirect
// are dropped.
// Optional feature: define IFETCH_HALT_DETECT_EN to stop fetching once a
// HALT_INST word has been accepted by decode.
module ifetch_512 #(
    parameter int              ADDR_W    = 9,
    parameter int              DATA_W    = 32,
    parameter int unsigned     RESET_PC  = 200,
    parameter logic [DATA_W-1:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HaltDetectEn = 1'b1;
`else
    localparam bit HaltDetectEn = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ResetPcVal = ADDR_W'(RESET_PC);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetchState_e;

    fetchState_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q;
    logic              epoch_q;
    logic              inflight_q;
    logic              inflightEpoch_q;
    logic [ADDR_W-1:0] inflightPc_q;
    logic [DATA_W-1:0] bufInst_q [0:1];
    logic [ADDR_W-1:0] bufPc_q   [0:1];
    logic              headIdx_q;
    logic [1:0]        bufCount_q;

    logic              running;
    logic              respValid;
    logic              bufNonEmpty;
    logic              pop;
    logic              popBuf;
    logic              push;
    logic              issue;
    logic              haltAccept;
    logic              wrIdx;
    logic [2:0]        occupancy;

    assign running     = (state_q == RUN);
    assign respValid   = inflight_q && (inflightEpoch_q == epoch_q);
    assign bufNonEmpty = (bufCount_q != 2'd0);
    assign wrIdx       = headIdx_q ^ bufCount_q[0];
    assign mem_addr    = pc_q;

    // State register: RUN normally, HALT only when halt detection is built in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a redirect always resumes fetching; an accepted halt word stops it.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (haltAccept) begin
            state_d = HALT;
        end
    end

    // Outputs: buffer head first, otherwise bypass a live response straight to decode.
    always_comb begin
        out_valid = 1'b0;
        out_inst  = '0;
        out_pc    = '0;
        if (running) begin
            if (bufNonEmpty) begin
                out_valid = 1'b1;
                out_inst  = bufInst_q[headIdx_q];
                out_pc    = bufPc_q[headIdx_q];
            end else if (respValid) begin
                out_valid = 1'b1;
                out_inst  = mem_dout;
                out_pc    = inflightPc_q;
            end
        end
        halted = HaltDetectEn && !running;
    end

    // Handshake and issue decisions; a request goes out only if its word is guaranteed a slot.
    always_comb begin
        pop        = out_valid && out_ready;
        popBuf     = pop && bufNonEmpty;
        haltAccept = HaltDetectEn && pop && (out_inst == HALT_INST);
        occupancy  = {1'b0, bufCount_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = !rst && running && !redirect_valid && !haltAccept && (occupancy < 3'd2);
        push       = respValid && running && !redirect_valid && !haltAccept
                     && !(pop && !bufNonEmpty);
        mem_rd_en  = issue;
    end

    // PC, epoch, in-flight tracking and skid buffer; redirect and halt flush everything pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q            <= ResetPcVal;
            epoch_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflightEpoch_q <= 1'b0;
            inflightPc_q    <= '0;
            headIdx_q       <= 1'b0;
            bufCount_q      <= 2'd0;
            bufInst_q[0]    <= '0;
            bufInst_q[1]    <= '0;
            bufPc_q[0]      <= '0;
            bufPc_q[1]      <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q            <= pc_q + ADDR_W'(1);
                inflightEpoch_q <= epoch_q;
                inflightPc_q    <= pc_q;
            end
            if (redirect_valid) begin
                pc_q       <= redirect_addr;
                epoch_q    <= ~epoch_q;
                headIdx_q  <= 1'b0;
                bufCount_q <= 2'd0;
            end else if (haltAccept) begin
                epoch_q    <= ~epoch_q;
                headIdx_q  <= 1'b0;
                bufCount_q <= 2'd0;
            end else begin
                if (push) begin
                    bufInst_q[wrIdx] <= mem_dout;
                    bufPc_q[wrIdx]   <= inflightPc_q;
                end
                if (popBuf) begin
                    headIdx_q <= ~headIdx_q;
                end
                case ({push, popBuf})
                    2'b10:   bufCount_q <= bufCount_q + 2'd1;
                    2'b01:   bufCount_q <= bufCount_q - 2'd1;
                    default: bufCount_q <= bufCount_q;
                endcase
            end
        end
    end

endmodule
